// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the FIFO write side.
// The arbiter takes the slave view; producers/FIFO (or a bench) take master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [OW-1:0]                 owner;
  logic                          busy;

  modport master (
    output req, req_data, full,
    input  gnt, ack, w_en, data_in, owner, busy
  );

  modport slave (
    input  req, req_data, full,
    output gnt, ack, w_en, data_in, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One producer owns the port for up to MAX_BURST accepted beats; the full
// flag stalls the burst without releasing it.

// Per-requester slice: gates ack and data by the registered grant bit.
module fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic                  req,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ack,
  output logic                  req_sel,
  output logic [DATA_WIDTH-1:0] data_sel
);
  // grant is one-hot, so the selected lane alone contributes to the OR trees
  always_comb begin
    ack      = sel & w_en;
    req_sel  = sel & req;
    data_sel = sel ? data : '0;
  end
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic [BW-1:0]        beat_q, beat_d;

  logic [NUM_REQ-1:0]                 req_sel;
  logic [NUM_REQ-1:0]                 ack_vec;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_sel;
  logic                               req_own;
  logic                               w_en;
  logic                               rel;
  logic [DATA_WIDTH-1:0]              data_mux;
  logic [OW-1:0]                      scan_base;
  logic                               pick_vld;
  logic [OW-1:0]                      pick_idx;

  // per-requester grant gating
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel      (gnt_q[g]),
      .req      (bus.req[g]),
      .w_en     (w_en),
      .data     (bus.req_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .ack      (ack_vec[g]),
      .req_sel  (req_sel[g]),
      .data_sel (data_sel[g])
    );
  end

  // write datapath; gnt_q is zero in IDLE so everything falls to 0 there
  always_comb begin
    req_own  = |req_sel;
    w_en     = (state_q == GRANT) & req_own & ~bus.full;
    rel      = (state_q == GRANT) &
               (~req_own | (w_en & (beat_q == BW'(MAX_BURST - 1))));
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) data_mux = data_mux | data_sel[i];
  end

  // round-robin scan: start just past the base, first requester wins.
  // In GRANT the scan is only consumed on release, where the base is the
  // releasing owner so it drops to lowest priority.
  always_comb begin : scan
    int cand;
    cand      = 0;
    scan_base = (state_q == GRANT) ? owner_q : last_q;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(scan_base) + k) % NUM_REQ;
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(cand);
      end
    end
  end

  // next-state: grant on demand, count beats, hand over without a bubble
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          last_d = owner_q;
          beat_d = '0;
          if (pick_vld) begin
            owner_d = pick_idx;
            gnt_d   = NUM_REQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (w_en) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // state register; requester 0 wins first after reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_vec;
  assign bus.w_en    = w_en;
  assign bus.data_in = data_mux;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all
// cycles checked against a queue-free behavioural model of the grant rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) if0 ();
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) if1 ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .bus(if0));
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .bus(if1));

  int nerr = 0;
  int nchk = 0;

  // model state per DUT (0: MAX_BURST=4, 1: MAX_BURST=1)
  int         mb [2] = '{4, 1};
  bit         m_busy [2];
  int         m_owner [2];
  int         m_last [2];
  int         m_beat [2];
  int         cnt [2][N];
  logic [N-1:0] rq [2];
  logic       fl [2];

  // last sampled DUT outputs
  logic [N-1:0]  a_gnt, a_ack;
  logic          a_wen, a_busy;
  logic [DW-1:0] a_data;
  logic [1:0]    a_owner;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // each producer emits base+count, base = A0, B0, C0, D0
  function automatic logic [DW-1:0] src(input int d, input int i);
    return 8'(8'hA0 + 16 * i + cnt[d][i]);
  endfunction

  task automatic apply();
    if0.req  = rq[0];
    if0.full = fl[0];
    if1.req  = rq[1];
    if1.full = fl[1];
    for (int i = 0; i < N; i++) begin
      if0.req_data[i*DW +: DW] = src(0, i);
      if1.req_data[i*DW +: DW] = src(1, i);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_owner[d] = 0;
      m_last[d]  = N - 1;
      m_beat[d]  = 0;
      rq[d]      = '0;
      fl[d]      = 1'b0;
      for (int i = 0; i < N; i++) cnt[d][i] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge wclk); #1;
    wrst_n = 1'b0;
    model_reset();
    apply();
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  // one clock: drive, sample at negedge, compare with model, advance model
  task automatic cycle(input int d);
    int o;
    logic [N-1:0] eg, ea;
    logic ew, eb, rel;
    logic [DW-1:0] ed;
    logic [1:0] eo;
    apply();
    @(negedge wclk);
    o  = m_owner[d];
    eb = m_busy[d];
    eg = eb ? (4'(1) << o) : 4'b0;
    ew = eb && rq[d][o] && !fl[d];
    ea = ew ? eg : 4'b0;
    ed = eb ? src(d, o) : 8'h00;
    eo = 2'(o);
    if (d == 0) begin
      a_gnt = if0.gnt; a_ack = if0.ack; a_wen = if0.w_en;
      a_data = if0.data_in; a_owner = if0.owner; a_busy = if0.busy;
    end else begin
      a_gnt = if1.gnt; a_ack = if1.ack; a_wen = if1.w_en;
      a_data = if1.data_in; a_owner = if1.owner; a_busy = if1.busy;
    end
    nchk++;
    if ({a_gnt, a_ack, a_wen, a_data, a_owner, a_busy} !== {eg, ea, ew, ed, eo, eb}) begin
      nerr++;
      $display("FAIL model dut%0d t=%0t: got gnt=%b ack=%b w_en=%b data=%h owner=%0d busy=%b, want gnt=%b ack=%b w_en=%b data=%h owner=%0d busy=%b",
               d, $time, a_gnt, a_ack, a_wen, a_data, a_owner, a_busy, eg, ea, ew, ed, eo, eb);
    end
    if (!eb) begin
      if (|rq[d]) begin
        m_owner[d] = pick(rq[d], m_last[d]);
        m_busy[d]  = 1'b1;
        m_beat[d]  = 0;
      end
    end else begin
      rel = !rq[d][o] || (ew && m_beat[d] == mb[d] - 1);
      if (rel) begin
        m_last[d] = o;
        m_beat[d] = 0;
        if (pick(rq[d], o) >= 0) m_owner[d] = pick(rq[d], o);
        else m_busy[d] = 1'b0;
      end else if (ew) begin
        m_beat[d]++;
      end
    end
    @(posedge wclk); #1;
    if (ew) cnt[d][o]++;
  endtask

  task automatic test_reset();
    #2;
    nchk++;
    if ({if0.gnt, if0.ack, if0.w_en, if0.data_in, if0.owner, if0.busy} !== '0) begin
      nerr++;
      $display("FAIL reset_state: gnt=%b ack=%b w_en=%b data=%h owner=%0d busy=%b, want all 0",
               if0.gnt, if0.ack, if0.w_en, if0.data_in, if0.owner, if0.busy);
    end
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    cycle(0);
    cycle(0);
  endtask

  task automatic test_single_stream();
    do_reset();
    rq[0] = 4'b0001;
    cycle(0);
    nchk++;
    if (a_gnt !== 4'b0000) begin
      nerr++; $display("FAIL stream_latency: gnt=%b want 0000", a_gnt);
    end
    for (int k = 0; k < 12; k++) begin
      cycle(0);
      nchk++;
      if (a_wen !== 1'b1 || a_gnt !== 4'b0001 || a_data !== 8'(8'hA0 + k)) begin
        nerr++;
        $display("FAIL stream_beat%0d: w_en=%b gnt=%b data=%h want 1 0001 %h",
                 k, a_wen, a_gnt, a_data, 8'(8'hA0 + k));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    rq[0] = 4'b1111;
    cycle(0);
    for (int k = 0; k < 17; k++) begin
      cycle(0);
      eg = 4'(1) << ((k / 4) % 4);
      nchk++;
      if (a_gnt !== eg || a_ack !== a_gnt || a_wen !== 1'b1) begin
        nerr++;
        $display("FAIL rr_cycle%0d: gnt=%b ack=%b w_en=%b want gnt=%b ack=gnt w_en=1",
                 k, a_gnt, a_ack, a_wen, eg);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] wr[$];
    do_reset();
    rq[0] = 4'b0100;
    cycle(0);
    repeat (2) begin cycle(0); if (a_wen) wr.push_back(a_data); end
    fl[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(0);
      if (a_wen) wr.push_back(a_data);
      nchk++;
      if (a_wen !== 1'b0 || a_ack !== 4'b0000 || a_gnt !== 4'b0100) begin
        nerr++;
        $display("FAIL full_stall%0d: w_en=%b ack=%b gnt=%b want 0 0000 0100", k, a_wen, a_ack, a_gnt);
      end
    end
    fl[0] = 1'b0;
    repeat (2) begin cycle(0); if (a_wen) wr.push_back(a_data); end
    rq[0] = 4'b0000;
    cycle(0);
    if (a_wen) wr.push_back(a_data);
    cycle(0);
    nchk++;
    if (a_gnt !== 4'b0000 || a_busy !== 1'b0) begin
      nerr++; $display("FAIL full_release: gnt=%b busy=%b want 0000 0", a_gnt, a_busy);
    end
    nchk++;
    if (wr.size() != 4 || wr[0] !== 8'hC0 || wr[1] !== 8'hC1 || wr[2] !== 8'hC2 || wr[3] !== 8'hC3) begin
      nerr++;
      $display("FAIL full_writes: count=%0d want 4 bytes C0..C3", wr.size());
    end
  endtask

  task automatic test_handover();
    do_reset();
    rq[0] = 4'b0011;
    cycle(0);
    cycle(0);
    cycle(0);
    rq[0] = 4'b0010;
    cycle(0);
    nchk++;
    if (a_gnt !== 4'b0001 || a_wen !== 1'b0 || a_busy !== 1'b1) begin
      nerr++;
      $display("FAIL handover_drop: gnt=%b w_en=%b busy=%b want 0001 0 1", a_gnt, a_wen, a_busy);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0);
      nchk++;
      if (a_gnt !== 4'b0010 || a_wen !== 1'b1 || a_busy !== 1'b1 || a_data !== 8'(8'hB0 + k)) begin
        nerr++;
        $display("FAIL handover_beat%0d: gnt=%b w_en=%b busy=%b data=%h want 0010 1 1 %h",
                 k, a_gnt, a_wen, a_busy, a_data, 8'(8'hB0 + k));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rq[0] = 4'b1000;
    cycle(0);
    cycle(0);
    cycle(0);
    #2;
    wrst_n = 1'b0;
    #1;
    nchk++;
    if (if0.gnt !== 4'b0000 || if0.busy !== 1'b0 || if0.w_en !== 1'b0 || if0.ack !== 4'b0000) begin
      nerr++;
      $display("FAIL async_reset: gnt=%b busy=%b w_en=%b ack=%b want all 0",
               if0.gnt, if0.busy, if0.w_en, if0.ack);
    end
    model_reset();
    apply();
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    rq[0] = 4'b1001;
    cycle(0);
    cycle(0);
    nchk++;
    if (a_owner !== 2'd0 || a_gnt !== 4'b0001) begin
      nerr++; $display("FAIL post_reset_winner: owner=%0d gnt=%b want 0 0001", a_owner, a_gnt);
    end
  endtask

  task automatic test_burst_one();
    do_reset();
    rq[1] = 4'b0101;
    cycle(1);
    for (int k = 0; k < 8; k++) begin
      cycle(1);
      nchk++;
      if (a_gnt !== ((k % 2 == 0) ? 4'b0001 : 4'b0100) || a_wen !== 1'b1 ||
          a_data !== ((k % 2 == 0) ? 8'(8'hA0 + k / 2) : 8'(8'hC0 + k / 2))) begin
        nerr++;
        $display("FAIL burst1_cycle%0d: gnt=%b w_en=%b data=%h", k, a_gnt, a_wen, a_data);
      end
    end
  endtask

  task automatic test_random(input int d, input int n);
    do_reset();
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq[d][i]) begin
          if ($urandom_range(0, 2) == 0) rq[d][i] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          rq[d][i] = 1'b0;
        end
      end
      fl[d] = ($urandom_range(0, 3) == 0);
      cycle(d);
      nchk++;
      if ($countones(a_gnt) > 1 || (a_wen && fl[d]) || (a_wen && a_gnt == '0)) begin
        nerr++;
        $display("FAIL random_invariant dut%0d: gnt=%b w_en=%b full=%b", d, a_gnt, a_wen, fl[d]);
      end
    end
  endtask

  initial begin
    model_reset();
    apply();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_full_stall();
    test_handover();
    test_async_reset();
    test_burst_one();
    test_random(0, 400);
    test_random(1, 200);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
